// File: rtl/pep_mmacc_boram_rd_ctrl.sv
// rtl/pep_mmacc_boram_rd_ctrl.sv - mmacc body RAM read controller
// Issues per-pid parity-tracked reads and pairs in-order returned body coefficients with their requests.
module pep_mmacc_boram_rd_ctrl #(
  parameter int TOTAL_PBS_NB = 16,
  parameter int PID_W        = $clog2(TOTAL_PBS_NB),
  parameter int LWE_COEF_W   = 12,
  parameter int INFO_W       = 8,
  parameter int OUTSTD_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  s_rst,
  input  logic [PID_W-1:0]                      cmd_pid,
  input  logic [INFO_W-1:0]                     cmd_info,
  input  logic                                  cmd_vld,
  output logic                                  cmd_rdy,
  output logic [PID_W-1:0]                      boram_rd_pid,
  output logic                                  boram_rd_parity,
  output logic                                  boram_rd_vld,
  input  logic                                  boram_rd_rdy,
  input  logic [LWE_COEF_W-1:0]                 boram_sxt_data,
  input  logic                                  boram_sxt_data_vld,
  output logic                                  boram_sxt_data_rdy,
  output logic [PID_W-1:0]                      sxt_pid,
  output logic [INFO_W-1:0]                     sxt_info,
  output logic [LWE_COEF_W-1:0]                 sxt_body,
  output logic                                  sxt_vld,
  input  logic                                  sxt_rdy,
  output logic [$clog2(OUTSTD_DEPTH+1)-1:0]     outstd_cnt,
  output logic                                  err_unexp_data
);

  localparam int PTR_W = (OUTSTD_DEPTH > 1) ? $clog2(OUTSTD_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTSTD_DEPTH + 1);

  logic [TOTAL_PBS_NB-1:0] parity_a;
  logic [TOTAL_PBS_NB-1:0] pending_a;
  logic [PID_W-1:0]        fifo_pid  [OUTSTD_DEPTH];
  logic [INFO_W-1:0]       fifo_info [OUTSTD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        cnt;

  logic fifo_full;
  logic fifo_empty;
  logic blocked;
  logic rd_hs;
  logic data_hs;
  logic pop;
  logic [PID_W-1:0] head_pid;

  // Full comes from the registered count, so a pop only frees a slot for issue on the next cycle.
  assign fifo_full  = (cnt == CNT_W'(OUTSTD_DEPTH));
  assign fifo_empty = (cnt == '0);
  assign head_pid   = fifo_pid[rd_ptr];

  assign blocked         = fifo_full | pending_a[cmd_pid];
  assign boram_rd_vld    = cmd_vld & ~blocked;
  assign cmd_rdy         = boram_rd_rdy & ~blocked;
  assign boram_rd_pid    = cmd_pid;
  assign boram_rd_parity = parity_a[cmd_pid];
  assign rd_hs           = cmd_vld & cmd_rdy;

  assign boram_sxt_data_rdy = ~sxt_vld | sxt_rdy;
  assign data_hs            = boram_sxt_data_vld & boram_sxt_data_rdy;
  assign pop                = data_hs & ~fifo_empty;

  assign outstd_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rd_hs) begin
      fifo_pid[wr_ptr]  <= cmd_pid;
      fifo_info[wr_ptr] <= cmd_info;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      parity_a       <= '0;
      pending_a      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      sxt_vld        <= 1'b0;
      sxt_pid        <= '0;
      sxt_info       <= '0;
      sxt_body       <= '0;
      err_unexp_data <= 1'b0;
    end else begin
      err_unexp_data <= data_hs & fifo_empty;

      if (rd_hs) begin
        wr_ptr            <= wr_ptr + 1'b1;
        parity_a[cmd_pid] <= ~parity_a[cmd_pid];
      end

      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sxt_pid  <= head_pid;
        sxt_info <= fifo_info[rd_ptr];
        sxt_body <= boram_sxt_data;
        sxt_vld  <= 1'b1;
      end else if (sxt_rdy) begin
        sxt_vld  <= 1'b0;
      end

      // Set is written last so it wins over a same-cycle clear of the same pid.
      if (pop)
        pending_a[head_pid] <= 1'b0;
      if (rd_hs)
        pending_a[cmd_pid] <= 1'b1;

      case ({rd_hs, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pep_mmacc_boram_rd_ctrl.sv
// tb/tb_pep_mmacc_boram_rd_ctrl.sv - scoreboard bench for pep_mmacc_boram_rd_ctrl
module tb_pep_mmacc_boram_rd_ctrl;

  logic        clk = 1'b0;
  logic        s_rst;
  logic [3:0]  cmd_pid;
  logic [7:0]  cmd_info;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [3:0]  boram_rd_pid;
  logic        boram_rd_parity;
  logic        boram_rd_vld;
  logic        boram_rd_rdy;
  logic [11:0] boram_sxt_data;
  logic        boram_sxt_data_vld;
  logic        boram_sxt_data_rdy;
  logic [3:0]  sxt_pid;
  logic [7:0]  sxt_info;
  logic [11:0] sxt_body;
  logic        sxt_vld;
  logic        sxt_rdy;
  logic [2:0]  outstd_cnt;
  logic        err_unexp_data;

  always #5 clk = ~clk;

  pep_mmacc_boram_rd_ctrl dut (
    .clk(clk), .s_rst(s_rst),
    .cmd_pid(cmd_pid), .cmd_info(cmd_info), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .boram_rd_pid(boram_rd_pid), .boram_rd_parity(boram_rd_parity),
    .boram_rd_vld(boram_rd_vld), .boram_rd_rdy(boram_rd_rdy),
    .boram_sxt_data(boram_sxt_data), .boram_sxt_data_vld(boram_sxt_data_vld),
    .boram_sxt_data_rdy(boram_sxt_data_rdy),
    .sxt_pid(sxt_pid), .sxt_info(sxt_info), .sxt_body(sxt_body),
    .sxt_vld(sxt_vld), .sxt_rdy(sxt_rdy),
    .outstd_cnt(outstd_cnt), .err_unexp_data(err_unexp_data)
  );

  typedef struct { logic [3:0] pid; logic [7:0] info; } rd_t;
  typedef struct { logic [3:0] pid; logic [7:0] info; logic [11:0] body; } out_t;

  rd_t  inflight[$];
  out_t exp_q[$];
  bit   par_m [16];
  bit   err_exp  = 1'b0;
  bit   rst_prev = 1'b0;
  int   errors   = 0;
  int   checks   = 0;
  int   issued   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake at %0t", name, $time);
  endtask

  function automatic bit pid_pending(input logic [3:0] p);
    foreach (inflight[i])
      if (inflight[i].pid == p) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a read is outstanding from its issue until its data is accepted;
  // the output slot holds at most one coefficient and follows the in-order read list.
  always @(negedge clk) begin
    bit   blocked;
    rd_t  r;
    out_t o;
    chk("outstd_cnt", 32'(outstd_cnt), 32'(inflight.size()));
    chk("sxt_vld", 32'(sxt_vld), 32'(exp_q.size() != 0));
    chk("err_unexp_data", 32'(err_unexp_data), 32'(err_exp));
    if (rst_prev) begin
      chk("rst_sxt_pid", 32'(sxt_pid), 32'd0);
      chk("rst_sxt_info", 32'(sxt_info), 32'd0);
      chk("rst_sxt_body", 32'(sxt_body), 32'd0);
    end
    blocked = (inflight.size() >= 4) || pid_pending(cmd_pid);
    chk("boram_rd_vld", 32'(boram_rd_vld), 32'(cmd_vld & !blocked));
    chk("cmd_rdy", 32'(cmd_rdy), 32'(boram_rd_rdy & !blocked));
    chk("data_rdy", 32'(boram_sxt_data_rdy), 32'(exp_q.size() == 0 || sxt_rdy));
    if (sxt_vld && sxt_rdy && exp_q.size() > 0) begin
      o = exp_q.pop_front();
      chk("sxt_pid", 32'(sxt_pid), 32'(o.pid));
      chk("sxt_info", 32'(sxt_info), 32'(o.info));
      chk("sxt_body", 32'(sxt_body), 32'(o.body));
    end
    err_exp = 1'b0;
    if (s_rst) begin
      inflight.delete();
      exp_q.delete();
      foreach (par_m[i]) par_m[i] = 1'b0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (boram_sxt_data_vld && boram_sxt_data_rdy) begin
        if (inflight.size() > 0) begin
          r = inflight.pop_front();
          exp_q.push_back('{pid: r.pid, info: r.info, body: boram_sxt_data});
        end else begin
          err_exp = 1'b1;
        end
      end
      if (cmd_vld && cmd_rdy) begin
        chk("rd_pid", 32'(boram_rd_pid), 32'(cmd_pid));
        chk("rd_parity", 32'(boram_rd_parity), 32'(par_m[cmd_pid]));
        par_m[cmd_pid] = ~par_m[cmd_pid];
        inflight.push_back('{pid: cmd_pid, info: cmd_info});
        issued++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] p, input logic [7:0] i);
    step(1);
    cmd_vld = 1'b1; cmd_pid = p; cmd_info = i; boram_rd_rdy = 1'b1;
  endtask

  task automatic wait_cmd();
    int n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) timeout_fail("cmd_handshake");
    step(1);
    cmd_vld = 1'b0;
  endtask

  task automatic issue(input logic [3:0] p, input logic [7:0] i);
    drive_cmd(p, i);
    wait_cmd();
  endtask

  task automatic ret(input logic [11:0] d);
    int n = 0;
    step(1);
    boram_sxt_data_vld = 1'b1; boram_sxt_data = d;
    @(negedge clk);
    while (!boram_sxt_data_rdy && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) timeout_fail("data_handshake");
    step(1);
    boram_sxt_data_vld = 1'b0;
  endtask

  initial begin
    int cyc;
    s_rst = 1'b1; cmd_vld = 1'b0; cmd_pid = '0; cmd_info = '0; boram_rd_rdy = 1'b0;
    boram_sxt_data = '0; boram_sxt_data_vld = 1'b0; sxt_rdy = 1'b1;
    step(2);
    s_rst = 1'b0;

    issue(4'd3, 8'hA5); step(1); ret(12'h123); step(2);
    issue(4'd3, 8'h11); ret(12'h456);
    issue(4'd3, 8'h22); ret(12'h789); step(2);

    issue(4'd5, 8'h50);
    drive_cmd(4'd5, 8'h51); step(3);
    ret(12'h0A0);
    wait_cmd(); ret(12'h0A1); step(2);

    issue(4'd0, 8'h10); issue(4'd1, 8'h11); issue(4'd2, 8'h12); issue(4'd3, 8'h13);
    drive_cmd(4'd4, 8'h14); step(2);
    ret(12'h200);
    wait_cmd();
    for (int k = 0; k < 4; k++) ret(12'h201 + 12'(k));
    step(2);

    issue(4'd6, 8'h60); issue(4'd7, 8'h70); issue(4'd8, 8'h80);
    sxt_rdy = 1'b0;
    ret(12'h300);
    fork
      ret(12'h301);
      begin step(4); sxt_rdy = 1'b1; end
    join
    ret(12'h302); step(2);

    ret(12'h055); step(3);

    issue(4'd9, 8'h90); issue(4'd10, 8'hA0); issue(4'd11, 8'hB0); issue(4'd12, 8'hC0);
    sxt_rdy = 1'b0;
    ret(12'h400); step(1);
    s_rst = 1'b1; step(1); s_rst = 1'b0; sxt_rdy = 1'b1; step(2);

    cyc = 0;
    while (issued < 10030 && cyc < 60000) begin
      step(1);
      cyc++;
      s_rst              = ($urandom % 4000) == 0;
      cmd_vld            = ($urandom % 10) < 7;
      cmd_pid            = 4'($urandom);
      cmd_info           = 8'($urandom);
      boram_rd_rdy       = ($urandom % 10) < 8;
      boram_sxt_data     = 12'($urandom);
      boram_sxt_data_vld = (inflight.size() > 0) ? (($urandom % 10) < 6) : (($urandom % 50) == 0);
      sxt_rdy            = ($urandom % 10) < 7;
    end
    if (issued < 10030) timeout_fail("random_issue_count");

    step(1);
    s_rst = 1'b0; cmd_vld = 1'b0; sxt_rdy = 1'b1; boram_sxt_data_vld = 1'b0;
    cyc = 0;
    while (inflight.size() > 0 && cyc < 100) begin
      ret(12'($urandom));
      cyc++;
    end
    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
